// File: rtl/nvm_gc_ctrl_pkg.sv
// Shared types and defaults for the NVM garbage-collection controller.
package nvm_gc_ctrl_pkg;

  localparam int unsigned BLOCK_W_DEF      = 10;
  localparam int unsigned PAGE_W_DEF       = 6;
  localparam int unsigned GC_THRESHOLD_DEF = 16;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INTERRUPT  = 4'd1,
    INI        = 4'd2,
    INI_DONE   = 4'd3,
    MOVE_START = 4'd4,
    MOVE_WAIT  = 4'd5,
    ERASE      = 4'd6,
    FINISH     = 4'd7
  } gc_state_t;

  typedef logic [BLOCK_W_DEF-1:0] block_t;
  typedef logic [PAGE_W_DEF-1:0]  page_t;

endpackage

// File: rtl/nvm_gc_ctrl_if.sv
// Page-move and block-erase handshakes between the GC controller and the flash sequencer.
interface nvm_gc_ctrl_if
  import nvm_gc_ctrl_pkg::*;
#(
  parameter int unsigned BLOCK_W = BLOCK_W_DEF,
  parameter int unsigned PAGE_W  = PAGE_W_DEF
);
  logic                       mv_req;
  logic [BLOCK_W+PAGE_W-1:0]  mv_src;
  logic                       mv_ack;
  logic                       mv_err;
  logic                       er_req;
  logic [BLOCK_W-1:0]         er_blk;
  logic                       er_ack;

  modport master (output mv_req, mv_src, er_req, er_blk,
                  input  mv_ack, mv_err, er_ack);
  modport slave  (input  mv_req, mv_src, er_req, er_blk,
                  output mv_ack, mv_err, er_ack);
endinterface

// File: rtl/nvm_gc_victim_sel.sv
// Running minimum over scanned blocks: fewest valid pages wins, ties keep the earlier index.
// GC_WEAR_LEVEL_EN: on equal valid count the lower erase count wins.
module nvm_gc_victim_sel
  import nvm_gc_ctrl_pkg::*;
#(
  parameter int unsigned BLOCK_W = BLOCK_W_DEF,
  parameter int unsigned PAGE_W  = PAGE_W_DEF
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               clr,
  input  logic               en,
  input  logic [PAGE_W:0]    vcnt,
  input  logic [15:0]        ecnt,
  input  logic [BLOCK_W-1:0] idx,
  output logic               found,
  output logic [PAGE_W:0]    best_vcnt,
  output logic [BLOCK_W-1:0] best_idx
);

  logic take_c;

`ifdef GC_WEAR_LEVEL_EN
  logic [15:0] best_ecnt;
  assign take_c = !found || (vcnt < best_vcnt) ||
                  ((vcnt == best_vcnt) && (ecnt < best_ecnt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                best_ecnt <= '0;
    else if (clr)             best_ecnt <= '0;
    else if (en && take_c)    best_ecnt <= ecnt;
  end
`else
  logic unused_ecnt;
  assign unused_ecnt = ^ecnt;
  assign take_c = !found || (vcnt < best_vcnt);
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      found     <= 1'b0;
      best_vcnt <= '0;
      best_idx  <= '0;
    end else if (clr) begin
      found     <= 1'b0;
      best_vcnt <= '0;
      best_idx  <= '0;
    end else if (en && take_c) begin
      found     <= 1'b1;
      best_vcnt <= vcnt;
      best_idx  <= idx;
    end
  end

endmodule

// File: rtl/nvm_gc_ctrl.sv
// GC controller: scan for the emptiest block, relocate its live pages, then erase it.
// GC_WEAR_LEVEL_EN selects erase-count tie-breaking in the victim selector.
module nvm_gc_ctrl
  import nvm_gc_ctrl_pkg::*;
#(
  parameter int unsigned BLOCK_W      = BLOCK_W_DEF,
  parameter int unsigned PAGE_W       = PAGE_W_DEF,
  parameter int unsigned GC_THRESHOLD = GC_THRESHOLD_DEF
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [BLOCK_W:0]          free_blocks,
  input  logic                      gc_force,
  input  logic                      host_busy,
  output logic [BLOCK_W-1:0]        scan_blk,
  input  logic [PAGE_W:0]           scan_vcnt,
  input  logic                      scan_skip,
  input  logic [15:0]               scan_ecnt,
  output logic [BLOCK_W+PAGE_W-1:0] page_addr,
  input  logic                      page_valid,
  nvm_gc_ctrl_if.master             gc_if,
  output logic                      gc_active,
  output logic                      gc_done,
  output logic                      gc_noop,
  output logic                      gc_err,
  output logic [3:0]                gc_state,
  output logic [PAGE_W:0]           moved_cnt
);

  localparam int unsigned NUM_BLOCKS = 2**BLOCK_W;
  localparam int unsigned PAGES      = 2**PAGE_W;
  localparam int unsigned ADDR_W     = BLOCK_W + PAGE_W;

  gc_state_t          state;
  logic               start_c;
  logic               last_blk_c;
  logic               last_page_c;
  logic               sel_found;
  logic [PAGE_W:0]    sel_vcnt;
  logic [BLOCK_W-1:0] sel_idx;
  logic [BLOCK_W-1:0] victim_c;

  assign start_c     = ((free_blocks < (BLOCK_W+1)'(GC_THRESHOLD)) || gc_force) && !host_busy;
  assign last_blk_c  = (scan_blk == BLOCK_W'(NUM_BLOCKS-1));
  assign last_page_c = (page_addr[PAGE_W-1:0] == PAGE_W'(PAGES-1));
  assign victim_c    = page_addr[ADDR_W-1:PAGE_W];
  assign gc_state    = state;

  nvm_gc_victim_sel #(
    .BLOCK_W (BLOCK_W),
    .PAGE_W  (PAGE_W)
  ) u_victim_sel (
    .CLK       (CLK),
    .nRST      (nRST),
    .clr       (state == IDLE),
    .en        ((state == INI) && !scan_skip),
    .vcnt      (scan_vcnt),
    .ecnt      (scan_ecnt),
    .idx       (scan_blk),
    .found     (sel_found),
    .best_vcnt (sel_vcnt),
    .best_idx  (sel_idx)
  );

  // page_addr doubles as the victim/page_idx register once INI_DONE latches the victim
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      scan_blk     <= '0;
      page_addr    <= '0;
      gc_if.mv_req <= 1'b0;
      gc_if.mv_src <= '0;
      gc_if.er_req <= 1'b0;
      gc_if.er_blk <= '0;
      gc_active    <= 1'b0;
      gc_done      <= 1'b0;
      gc_noop      <= 1'b0;
      gc_err       <= 1'b0;
      moved_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start_c) begin
          state     <= INI;
          gc_active <= 1'b1;
          moved_cnt <= '0;
          scan_blk  <= '0;
        end
        INI: begin
          if (last_blk_c) state <= INI_DONE;
          else            scan_blk <= scan_blk + BLOCK_W'(1);
        end
        INI_DONE: begin
          if (!sel_found || (sel_vcnt == (PAGE_W+1)'(PAGES))) begin
            state   <= FINISH;
            gc_done <= 1'b1;
            gc_noop <= 1'b1;
          end else begin
            page_addr <= {sel_idx, PAGE_W'(0)};
            state     <= MOVE_START;
          end
        end
        MOVE_START: begin
          if (host_busy) begin
            state <= INTERRUPT;
          end else if (page_valid) begin
            gc_if.mv_req <= 1'b1;
            gc_if.mv_src <= page_addr;
            state        <= MOVE_WAIT;
          end else if (last_page_c) begin
            gc_if.er_req <= 1'b1;
            gc_if.er_blk <= victim_c;
            state        <= ERASE;
          end else begin
            page_addr <= page_addr + ADDR_W'(1);
          end
        end
        INTERRUPT: if (!host_busy) state <= MOVE_START;
        MOVE_WAIT: if (gc_if.mv_ack) begin
          gc_if.mv_req <= 1'b0;
          if (gc_if.mv_err) begin
            state   <= FINISH;
            gc_done <= 1'b1;
            gc_err  <= 1'b1;
          end else begin
            moved_cnt <= moved_cnt + (PAGE_W+1)'(1);
            if (last_page_c) begin
              gc_if.er_req <= 1'b1;
              gc_if.er_blk <= victim_c;
              state        <= ERASE;
            end else begin
              page_addr <= page_addr + ADDR_W'(1);
              state     <= MOVE_START;
            end
          end
        end
        ERASE: if (gc_if.er_ack) begin
          gc_if.er_req <= 1'b0;
          gc_done      <= 1'b1;
          state        <= FINISH;
        end
        FINISH: begin
          gc_done   <= 1'b0;
          gc_noop   <= 1'b0;
          gc_err    <= 1'b0;
          gc_active <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_gc_ctrl.sv
// Directed bench for nvm_gc_ctrl at BLOCK_W=3, PAGE_W=2, GC_THRESHOLD=2.
module tb_nvm_gc_ctrl;
  import nvm_gc_ctrl_pkg::*;

`ifdef GC_WEAR_LEVEL_EN
  localparam logic [2:0] TIE_VICTIM = 3'd4;
`else
  localparam logic [2:0] TIE_VICTIM = 3'd2;
`endif

  logic        CLK;
  logic        nRST;
  logic [3:0]  free_blocks;
  logic        gc_force;
  logic        host_busy;
  logic [2:0]  scan_blk;
  logic [2:0]  scan_vcnt;
  logic        scan_skip;
  logic [15:0] scan_ecnt;
  logic [4:0]  page_addr;
  logic        page_valid;
  logic        gc_active, gc_done, gc_noop, gc_err;
  logic [3:0]  gc_state;
  logic [2:0]  moved_cnt;

  logic [2:0]  vcnt_tab [8];
  logic        skip_tab [8];
  logic [15:0] ecnt_tab [8];
  logic        valid_tab [4];

  int checks = 0;
  int errors = 0;

  nvm_gc_ctrl_if #(.BLOCK_W(3), .PAGE_W(2)) gif ();

  nvm_gc_ctrl #(.BLOCK_W(3), .PAGE_W(2), .GC_THRESHOLD(2)) dut (
    .CLK(CLK), .nRST(nRST), .free_blocks(free_blocks), .gc_force(gc_force),
    .host_busy(host_busy), .scan_blk(scan_blk), .scan_vcnt(scan_vcnt),
    .scan_skip(scan_skip), .scan_ecnt(scan_ecnt), .page_addr(page_addr),
    .page_valid(page_valid), .gc_if(gif.master), .gc_active(gc_active),
    .gc_done(gc_done), .gc_noop(gc_noop), .gc_err(gc_err),
    .gc_state(gc_state), .moved_cnt(moved_cnt)
  );

  assign scan_vcnt  = vcnt_tab[scan_blk];
  assign scan_skip  = skip_tab[scan_blk];
  assign scan_ecnt  = ecnt_tab[scan_blk];
  assign page_valid = valid_tab[page_addr[1:0]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Flash-sequencer stand-in: acks moves after ack_delay cycles and logs what it saw
  bit         rec_clr = 1'b1;
  int         ack_delay = 1;
  bit         err_first = 1'b0;
  bit         hold_erase = 1'b0;
  int         wcnt = 0;
  int         mv_cnt = 0;
  int         er_cnt = 0;
  int         ms_cycles = 0;
  logic [4:0] mv_log [4];
  logic [2:0] er_seen = 3'd0;

  always @(negedge CLK) begin
    if (rec_clr) begin
      mv_cnt <= 0; er_cnt <= 0; ms_cycles <= 0; wcnt <= 0;
      gif.mv_ack <= 1'b0; gif.mv_err <= 1'b0; gif.er_ack <= 1'b0;
    end else begin
      if (gc_state == 4'(MOVE_START)) ms_cycles <= ms_cycles + 1;
      if (gif.mv_ack) begin
        gif.mv_ack <= 1'b0; gif.mv_err <= 1'b0; wcnt <= 0;
      end else if (gif.mv_req) begin
        if (wcnt + 1 >= ack_delay) begin
          gif.mv_ack <= 1'b1;
          gif.mv_err <= err_first && (mv_cnt == 0);
          mv_log[mv_cnt[1:0]] <= gif.mv_src;
          mv_cnt <= mv_cnt + 1;
          wcnt <= 0;
        end else begin
          wcnt <= wcnt + 1;
        end
      end
      if (gif.er_ack) gif.er_ack <= 1'b0;
      else if (gif.er_req && !hold_erase) begin
        gif.er_ack <= 1'b1; er_seen <= gif.er_blk; er_cnt <= er_cnt + 1;
      end
    end
  end

  bit         d_noop, d_err;
  logic [2:0] d_moved;

  task automatic do_reset();
    nRST = 1'b0; rec_clr = 1'b1; free_blocks = 4'd4; gc_force = 1'b0; host_busy = 1'b0;
    ack_delay = 1; err_first = 1'b0; hold_erase = 1'b0;
    for (int i = 0; i < 8; i++) begin vcnt_tab[i] = 3'd4; skip_tab[i] = 1'b0; ecnt_tab[i] = 16'd0; end
    for (int i = 0; i < 4; i++) valid_tab[i] = 1'b0;
    repeat (2) @(negedge CLK);
    #1 nRST = 1'b1; rec_clr = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit keep, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK); #1;
      if (gc_done) begin
        ok = 1'b1; d_noop = gc_noop; d_err = gc_err; d_moved = moved_cnt;
        if (!keep) free_blocks = 4'd4;
      end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL done_timeout: gc_done not seen in %0d cycles", budget); end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK); #1;
    checks++; if (gc_state !== 4'(IDLE)) begin errors++; $display("FAIL rst_state: got %0d want 0", gc_state); end
    checks++; if ({gif.mv_req, gif.er_req, gc_done, gc_active, gc_noop, gc_err} !== 6'b0) begin
      errors++; $display("FAIL rst_flags: got %b want 000000", {gif.mv_req, gif.er_req, gc_done, gc_active, gc_noop, gc_err}); end
    checks++; if ({scan_blk, page_addr, gif.mv_src, gif.er_blk, moved_cnt} !== 17'd0) begin
      errors++; $display("FAIL rst_regs: got %h want 0", {scan_blk, page_addr, gif.mv_src, gif.er_blk, moved_cnt}); end
  endtask

  task automatic test_victim();
    bit ok;
    do_reset();
    vcnt_tab = '{3'd4, 3'd3, 3'd1, 3'd2, 3'd1, 3'd4, 3'd4, 3'd4};
    valid_tab = '{1'b1, 1'b0, 1'b0, 1'b1};
    free_blocks = 4'd1;
    @(negedge CLK); #1;
    checks++; if (gc_state !== 4'(INI) || gc_active !== 1'b1) begin
      errors++; $display("FAIL vic_start: state %0d active %b want 2 1", gc_state, gc_active); end
    wait_done(200, 1'b0, ok);
    checks++; if (mv_cnt !== 2) begin errors++; $display("FAIL vic_mv_cnt: got %0d want 2", mv_cnt); end
    checks++; if (mv_log[0] !== 5'h08 || mv_log[1] !== 5'h0B) begin
      errors++; $display("FAIL vic_mv_src: got %h %h want 08 0b", mv_log[0], mv_log[1]); end
    checks++; if (er_cnt !== 1 || er_seen !== 3'd2) begin
      errors++; $display("FAIL vic_erase: cnt %0d blk %0d want 1 2", er_cnt, er_seen); end
    checks++; if (d_moved !== 3'd2 || d_noop !== 1'b0 || d_err !== 1'b0) begin
      errors++; $display("FAIL vic_status: moved %0d noop %b err %b want 2 0 0", d_moved, d_noop, d_err); end
    @(negedge CLK); #1;
    checks++; if (gc_state !== 4'(IDLE) || gc_active !== 1'b0 || gc_done !== 1'b0) begin
      errors++; $display("FAIL vic_idle: state %0d active %b done %b want 0 0 0", gc_state, gc_active, gc_done); end
  endtask

  task automatic test_empty_victim();
    bit ok;
    do_reset();
    vcnt_tab = '{3'd4, 3'd4, 3'd0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    free_blocks = 4'd1;
    wait_done(200, 1'b0, ok);
    checks++; if (mv_cnt !== 0) begin errors++; $display("FAIL empty_mv: got %0d want 0", mv_cnt); end
    checks++; if (ms_cycles !== 4) begin errors++; $display("FAIL empty_ms_cycles: got %0d want 4", ms_cycles); end
    checks++; if (er_cnt !== 1 || er_seen !== 3'd2 || d_noop !== 1'b0) begin
      errors++; $display("FAIL empty_erase: cnt %0d blk %0d noop %b want 1 2 0", er_cnt, er_seen, d_noop); end
  endtask

  task automatic test_no_gain();
    bit ok;
    do_reset();
    free_blocks = 4'd1;
    wait_done(100, 1'b0, ok);
    checks++; if (d_noop !== 1'b1 || er_cnt !== 0 || mv_cnt !== 0) begin
      errors++; $display("FAIL nogain_full: noop %b er %0d mv %0d want 1 0 0", d_noop, er_cnt, mv_cnt); end
    do_reset();
    vcnt_tab = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd1, 3'd0, 3'd3};
    for (int i = 0; i < 8; i++) skip_tab[i] = 1'b1;
    free_blocks = 4'd1;
    wait_done(100, 1'b0, ok);
    checks++; if (d_noop !== 1'b1 || er_cnt !== 0 || mv_cnt !== 0) begin
      errors++; $display("FAIL nogain_skip: noop %b er %0d mv %0d want 1 0 0", d_noop, er_cnt, mv_cnt); end
  endtask

  task automatic test_host_yield();
    bit ok;
    bit seen;
    do_reset();
    vcnt_tab = '{3'd4, 3'd4, 3'd1, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    valid_tab = '{1'b1, 1'b1, 1'b0, 1'b0};
    ack_delay = 4;
    free_blocks = 4'd1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge CLK); #1; seen = gif.mv_req; end
    checks++; if (!seen) begin errors++; $display("FAIL yield_req_timeout: mv_req 0 want 1"); end
    host_busy = 1'b1;
    @(negedge CLK); #1;
    checks++; if (gif.mv_req !== 1'b1 || gc_state !== 4'(MOVE_WAIT)) begin
      errors++; $display("FAIL yield_hold: req %b state %0d want 1 5", gif.mv_req, gc_state); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge CLK); #1; seen = (gc_state == 4'(INTERRUPT)); end
    checks++; if (!seen || mv_cnt !== 1 || moved_cnt !== 3'd1 || gif.mv_req !== 1'b0) begin
      errors++; $display("FAIL yield_int: seen %b mv %0d moved %0d req %b want 1 1 1 0", seen, mv_cnt, moved_cnt, gif.mv_req); end
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (gc_state !== 4'(INTERRUPT) || page_addr !== 5'h09 || mv_cnt !== 1) begin
      errors++; $display("FAIL yield_wait: state %0d addr %h mv %0d want 1 09 1", gc_state, page_addr, mv_cnt); end
    host_busy = 1'b0;
    wait_done(100, 1'b0, ok);
    checks++; if (mv_log[1] !== 5'h09 || d_moved !== 3'd2 || er_seen !== 3'd2) begin
      errors++; $display("FAIL yield_resume: src %h moved %0d blk %0d want 09 2 2", mv_log[1], d_moved, er_seen); end
  endtask

  task automatic test_move_err();
    bit ok;
    do_reset();
    vcnt_tab = '{3'd4, 3'd3, 3'd1, 3'd2, 3'd1, 3'd4, 3'd4, 3'd4};
    valid_tab = '{1'b1, 1'b0, 1'b0, 1'b1};
    err_first = 1'b1;
    free_blocks = 4'd1;
    wait_done(100, 1'b0, ok);
    checks++; if (d_err !== 1'b1 || d_noop !== 1'b0 || d_moved !== 3'd0) begin
      errors++; $display("FAIL err_status: err %b noop %b moved %0d want 1 0 0", d_err, d_noop, d_moved); end
    checks++; if (er_cnt !== 0 || mv_cnt !== 1) begin
      errors++; $display("FAIL err_counts: er %0d mv %0d want 0 1", er_cnt, mv_cnt); end
    @(negedge CLK); #1;
    checks++; if (gc_state !== 4'(IDLE) || gif.er_req !== 1'b0) begin
      errors++; $display("FAIL err_idle: state %0d er_req %b want 0 0", gc_state, gif.er_req); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    vcnt_tab = '{3'd4, 3'd4, 3'd0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    hold_erase = 1'b1;
    free_blocks = 4'd1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge CLK); #1; seen = gif.er_req; end
    checks++; if (!seen || gc_state !== 4'(ERASE) || gif.er_blk !== 3'd2) begin
      errors++; $display("FAIL rmid_erase: seen %b state %0d blk %0d want 1 6 2", seen, gc_state, gif.er_blk); end
    #1 nRST = 1'b0;
    #1;
    checks++; if (gif.er_req !== 1'b0 || gc_state !== 4'(IDLE) || gc_active !== 1'b0) begin
      errors++; $display("FAIL rmid_async: er_req %b state %0d active %b want 0 0 0", gif.er_req, gc_state, gc_active); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    free_blocks = 4'd1;
    wait_done(100, 1'b1, ok);
    @(negedge CLK); #1;
    checks++; if (gc_state !== 4'(IDLE)) begin errors++; $display("FAIL b2b_idle: got %0d want 0", gc_state); end
    @(negedge CLK); #1;
    checks++; if (gc_state !== 4'(INI) || scan_blk !== 3'd0) begin
      errors++; $display("FAIL b2b_retrig: state %0d blk %0d want 2 0", gc_state, scan_blk); end
    free_blocks = 4'd4;
    wait_done(100, 1'b0, ok);
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (gc_state !== 4'(IDLE)) begin errors++; $display("FAIL b2b_stay: got %0d want 0", gc_state); end
  endtask

  task automatic test_force();
    bit ok;
    do_reset();
    gc_force = 1'b1;
    @(negedge CLK); #1;
    checks++; if (gc_state !== 4'(INI)) begin errors++; $display("FAIL force_start: got %0d want 2", gc_state); end
    gc_force = 1'b0;
    wait_done(100, 1'b0, ok);
    checks++; if (d_noop !== 1'b1) begin errors++; $display("FAIL force_noop: got %b want 1", d_noop); end
  endtask

  task automatic test_tie_break();
    bit ok;
    do_reset();
    vcnt_tab = '{3'd4, 3'd4, 3'd1, 3'd4, 3'd1, 3'd4, 3'd4, 3'd4};
    ecnt_tab[2] = 16'd9;
    ecnt_tab[4] = 16'd3;
    free_blocks = 4'd1;
    wait_done(200, 1'b0, ok);
    checks++; if (er_seen !== TIE_VICTIM || er_cnt !== 1) begin
      errors++; $display("FAIL tie_victim: blk %0d cnt %0d want %0d 1", er_seen, er_cnt, TIE_VICTIM); end
  endtask

  initial begin
    test_reset();
    test_victim();
    test_empty_victim();
    test_no_gain();
    test_host_yield();
    test_move_err();
    test_reset_mid();
    test_back_to_back();
    test_force();
    test_tie_break();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
